// File: rtl/dct_pkg.sv
// Shared types and constants for the 8-point DCT datapath.
package dct_pkg;

  localparam int unsigned DCT_N      = 8;
  localparam int unsigned DCT_DATA_W = 32;
  localparam int unsigned DCT_FRAC   = 8;

  typedef logic signed [DCT_DATA_W-1:0] coef_t;
  typedef coef_t [DCT_N-1:0]            coef_vec_t;
  typedef logic [2:0]                   idx_t;

endpackage

// File: rtl/dct_tp_bank.sv
// One 8x8 coefficient bank: whole-row write port, combinational whole-column read port.
module dct_tp_bank
  import dct_pkg::*;
(
  input  logic      clk,
  input  logic      we_i,
  input  idx_t      wr_row_i,
  input  coef_vec_t wr_data_i,
  input  idx_t      rd_col_i,
  output coef_vec_t rd_data_o
);

  // Storage is intentionally unreset; validity is tracked by the owner's full flags.
  coef_vec_t mem_q [DCT_N];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wr_row_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < int'(DCT_N); k++) begin
      rd_data_o[k] = mem_q[k][rd_col_i];
    end
  end

endmodule

// File: rtl/dct_transpose_buf.sv
// Ping-pong 8x8 transpose buffer: rows in from the row-pass DCT, columns out to the column pass.
// Only N=8 is supported (3-bit row/column indices).
module dct_transpose_buf
  import dct_pkg::*;
#(
  parameter int unsigned DATA_W = DCT_DATA_W,
  parameter int unsigned N      = DCT_N
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_row,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*DATA_W-1:0] out_col,
  output logic [2:0]          out_idx,
  output logic                out_last
);

  localparam idx_t LAST_IDX = 3'(N - 1);

  logic [1:0] full_q, full_d;
  logic       wbank_q, wbank_d;
  logic       rbank_q, rbank_d;
  idx_t       wrow_q, wrow_d;
  idx_t       rcol_q, rcol_d;

  logic       in_fire;
  logic       out_fire;
  coef_vec_t  wr_data;
  coef_vec_t  bank0_col;
  coef_vec_t  bank1_col;

  assign in_ready  = ~full_q[wbank_q];
  assign out_valid = full_q[rbank_q];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign wr_data   = coef_vec_t'(in_row);

  // A bank can be completed and freed in one cycle only if they are different banks,
  // so the two flag updates never collide.
  always_comb begin
    full_d  = full_q;
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    wrow_d  = wrow_q;
    rcol_d  = rcol_q;

    if (in_fire) begin
      if (wrow_q == LAST_IDX) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
        wrow_d          = '0;
      end else begin
        wrow_d = wrow_q + 3'd1;
      end
    end

    if (out_fire) begin
      if (rcol_q == LAST_IDX) begin
        full_d[rbank_q] = 1'b0;
        rbank_d         = ~rbank_q;
        rcol_d          = '0;
      end else begin
        rcol_d = rcol_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q  <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      wrow_q  <= '0;
      rcol_q  <= '0;
    end else begin
      full_q  <= full_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      wrow_q  <= wrow_d;
      rcol_q  <= rcol_d;
    end
  end

  dct_tp_bank u_bank0 (
    .clk       (clk),
    .we_i      (in_fire & ~wbank_q),
    .wr_row_i  (wrow_q),
    .wr_data_i (wr_data),
    .rd_col_i  (rcol_q),
    .rd_data_o (bank0_col)
  );

  dct_tp_bank u_bank1 (
    .clk       (clk),
    .we_i      (in_fire & wbank_q),
    .wr_row_i  (wrow_q),
    .wr_data_i (wr_data),
    .rd_col_i  (rcol_q),
    .rd_data_o (bank1_col)
  );

  assign out_col  = rbank_q ? bank1_col : bank0_col;
  assign out_idx  = rcol_q;
  assign out_last = (rcol_q == LAST_IDX);

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Self-checking bench for dct_transpose_buf: directed table, corner sequences, random scoreboard.
module tb_dct_transpose_buf;
  import dct_pkg::*;

  localparam int unsigned W = DCT_N * DCT_DATA_W;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_row;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_col;
  logic [2:0]   out_idx;
  logic         out_last;

  always #5 clk = ~clk;

  dct_transpose_buf dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  function automatic logic [W-1:0] mkrow(int base);
    logic [W-1:0] r;
    for (int j = 0; j < 8; j++) r[j*32 +: 32] = 32'(base + j);
    return r;
  endfunction

  function automatic logic [31:0] rnd_elem();
    case ($urandom_range(0, 3))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [W-1:0] rnd_row();
    logic [W-1:0] r;
    for (int j = 0; j < 8; j++) r[j*32 +: 32] = rnd_elem();
    return r;
  endfunction

  // Scoreboard: rows accepted are grouped into blocks and transposed into expected columns
  typedef struct {
    logic [W-1:0] col;
    logic [2:0]   idx;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] acc [8];
  int           wr_cnt = 0;
  logic         stall_prev = 1'b0;
  logic [W-1:0] stall_col;
  logic [2:0]   stall_idx;

  always @(negedge clk) begin
    if (rst) begin
      wr_cnt     = 0;
      stall_prev = 1'b0;
      exp_q.delete();
    end else begin
      if (stall_prev) begin
        chk("stall_valid", W'(out_valid), W'(1'b1));
        chk("stall_col", out_col, stall_col);
        chk("stall_idx", W'(out_idx), W'(stall_idx));
      end
      if (in_valid && in_ready) begin
        acc[wr_cnt] = in_row;
        wr_cnt++;
        if (wr_cnt == 8) begin
          for (int c = 0; c < 8; c++) begin
            exp_t e;
            for (int k = 0; k < 8; k++) e.col[k*32 +: 32] = acc[k][c*32 +: 32];
            e.idx = 3'(c);
            exp_q.push_back(e);
          end
          wr_cnt = 0;
        end
      end
      if (out_valid && out_ready) begin
        chk("sb_nonempty", W'(exp_q.size() != 0), W'(1'b1));
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_col", out_col, e.col);
          chk("sb_idx", W'(out_idx), W'(e.idx));
          chk("sb_last", W'(out_last), W'(e.idx == 3'd7));
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_col  = out_col;
      stall_idx  = out_idx;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input logic [W-1:0] row, input logic ordy);
    logic ok;
    ok        = 1'b0;
    in_valid  = 1'b1;
    in_row    = row;
    out_ready = ordy;
    for (int n = 0; n < 100 && !ok; n++) begin
      #1;
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    chk("send_accepted", W'(ok), W'(1'b1));
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) tick();
    chk("drain_empty", W'(exp_q.size()), W'(0));
    chk("drain_valid", W'(out_valid), W'(1'b0));
  endtask

  typedef struct {
    logic         iv;
    logic [W-1:0] row;
    logic         ordy;
    logic         e_rdy;
    logic         e_val;
    logic [2:0]   e_idx;
    logic         e_last;
    logic [W-1:0] e_col;
  } vec_t;

  vec_t tv [17];

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_row    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", W'(in_ready), W'(1'b1));
    chk("rst_out_valid", W'(out_valid), W'(1'b0));
    chk("rst_out_idx", W'(out_idx), W'(0));
    chk("rst_out_last", W'(out_last), W'(1'b0));

    // Test 1: single block, element j of row r = 16r+j, expect column c element k = 16k+c
    for (int i = 0; i < 17; i++) begin
      tv[i].iv     = (i < 8);
      tv[i].row    = (i < 8) ? mkrow(16 * i) : '0;
      tv[i].ordy   = 1'b1;
      tv[i].e_rdy  = 1'b1;
      tv[i].e_val  = (i >= 8 && i < 16);
      tv[i].e_idx  = (i >= 8 && i < 16) ? 3'(i - 8) : 3'd0;
      tv[i].e_last = (i == 15);
      tv[i].e_col  = '0;
      if (i >= 8 && i < 16)
        for (int k = 0; k < 8; k++) tv[i].e_col[k*32 +: 32] = 32'(16 * k + (i - 8));
    end
    for (int i = 0; i < 17; i++) begin
      in_valid  = tv[i].iv;
      in_row    = tv[i].row;
      out_ready = tv[i].ordy;
      #1;
      chk($sformatf("t1_rdy[%0d]", i), W'(in_ready), W'(tv[i].e_rdy));
      chk($sformatf("t1_val[%0d]", i), W'(out_valid), W'(tv[i].e_val));
      chk($sformatf("t1_idx[%0d]", i), W'(out_idx), W'(tv[i].e_idx));
      chk($sformatf("t1_last[%0d]", i), W'(out_last), W'(tv[i].e_last));
      if (tv[i].e_val) chk($sformatf("t1_col[%0d]", i), out_col, tv[i].e_col);
      tick();
    end

    // Test 2: three back-to-back blocks at full rate
    for (int cyc = 0; cyc < 40; cyc++) begin
      in_valid  = (cyc < 24);
      in_row    = mkrow(1000 * (cyc / 8) + 100 * (cyc % 8));
      out_ready = 1'b1;
      #1;
      if (cyc < 24) chk("t2_in_ready", W'(in_ready), W'(1'b1));
      if (cyc >= 8 && cyc < 32) chk("t2_no_bubble", W'(out_valid), W'(1'b1));
      if (cyc == 32) chk("t2_idle", W'(out_valid), W'(1'b0));
      tick();
    end
    in_valid = 1'b0;
    chk("t2_empty", W'(exp_q.size()), W'(0));

    // Test 3: downstream stalled while two blocks fill both banks
    for (int r = 0; r < 16; r++) begin
      in_valid  = 1'b1;
      in_row    = mkrow(5000 + 16 * r);
      out_ready = 1'b0;
      #1;
      chk("t3_fill_ready", W'(in_ready), W'(1'b1));
      tick();
    end
    in_row = mkrow(7000);
    for (int n = 0; n < 4; n++) begin
      #1;
      chk("t3_full_stall", W'(in_ready), W'(1'b0));
      chk("t3_full_idx", W'(out_idx), W'(0));
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("t3_drainA_rdy", W'(in_ready), W'(1'b0));
      chk("t3_drainA_idx", W'(out_idx), W'(k));
      tick();
    end
    #1;
    chk("t3_ready_back", W'(in_ready), W'(1'b1));
    chk("t3_B_col0", W'(out_idx), W'(0));
    tick();
    for (int r = 1; r < 8; r++) send_row(mkrow(7000 + 16 * r), 1'b1);
    drain();

    // Test 4: random valid/ready with extreme signed values
    begin
      int           sent;
      logic         fired;
      logic [W-1:0] cur;
      sent = 0;
      cur  = rnd_row();
      for (int n = 0; n < 30000 && sent < 800; n++) begin
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        in_row    = cur;
        #1;
        fired = in_valid && in_ready;
        tick();
        if (fired) begin
          sent++;
          cur = rnd_row();
        end
      end
      chk("t4_rows_sent", W'(sent), W'(800));
      drain();
    end

    // Test 5: reset mid-fill, then mid-drain at column 3
    for (int r = 0; r < 5; r++) send_row(mkrow(9000 + 16 * r), 1'b1);
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("t5a_in_ready", W'(in_ready), W'(1'b1));
    chk("t5a_out_valid", W'(out_valid), W'(1'b0));
    chk("t5a_out_idx", W'(out_idx), W'(0));
    for (int r = 0; r < 8; r++) send_row(mkrow(9500 + 16 * r), 1'b0);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("t5b_pre_idx", W'(out_idx), W'(3));
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    chk("t5b_in_ready", W'(in_ready), W'(1'b1));
    chk("t5b_out_valid", W'(out_valid), W'(1'b0));
    chk("t5b_out_idx", W'(out_idx), W'(0));
    chk("t5b_out_last", W'(out_last), W'(1'b0));
    for (int r = 0; r < 8; r++) send_row(mkrow(-300 + 16 * r), 1'b0);
    chk("t5_first_valid", W'(out_valid), W'(1'b1));
    chk("t5_first_idx", W'(out_idx), W'(0));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
